// File: rtl/serial_paralelo_if.sv
// serial_paralelo_if -- lane signals between the serial link and the
// receive-side deserializer.
//   data_in    : serial bit stream, MSB of each byte first
//   data_out   : last received data byte, held between strobes
//   valid_out  : one-cycle strobe when data_out takes a new non-comma byte
//   active_out : high while the deserializer is byte-locked
//   idle_out   : high while locked and the last completed byte was a comma
// Modports: slave = deserializer, master = link/byte-domain side.
interface serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active_out;
  logic       idle_out;

  modport slave (
    input  data_in,
    output data_out, valid_out, active_out, idle_out
  );

  modport master (
    output data_in,
    input  data_out, valid_out, active_out, idle_out
  );
endinterface

// File: rtl/serial_paralelo.sv
// serial_paralelo -- receive-side deserializer.
// Hunts the MSB-first bit stream for the comma character, confirms byte
// alignment over LOCK_BC consecutive aligned commas, then presents every
// non-comma byte on data_out with a one-cycle valid_out strobe.
// Ports:
//   clk_32f : bit-rate clock, one serial bit sampled per rising edge
//   reset   : synchronous, active-high
//   bus     : serial_paralelo_if.slave (data_in in; data_out, valid_out,
//             active_out, idle_out out -- all outputs registered)
module serial_paralelo #(
  parameter int unsigned LOCK_BC   = 4,      // legal range 1..15
  parameter logic [7:0]  IDLE_CHAR = 8'hBC
) (
  input  logic               clk_32f,
  input  logic               reset,
  serial_paralelo_if.slave   bus
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_BC);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,  // bit-level hunt for a comma
    SYNC   = 2'd1,  // byte-level confirmation of alignment
    ACTIVE = 2'd2   // locked, delivering bytes
  } state_t;

  state_t     state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic [7:0] data_q;
  logic       valid_q;
  logic       active_q;
  logic       idle_q;

  // Byte that would be complete if this edge were a byte boundary.
  logic [7:0] cand;
  logic       is_comma;
  logic       boundary;

  assign cand     = {sr[6:0], bus.data_in};
  assign is_comma = (cand == IDLE_CHAR);
  assign boundary = (bit_cnt == 3'd7);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others; blocking here would
  // make the shift register and the comparisons see partially updated data.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= SEARCH;
      sr       <= 8'h00;
      bit_cnt  <= 3'd0;
      bc_cnt   <= 4'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      sr      <= cand;
      valid_q <= 1'b0;

      case (state)
        SEARCH: begin
          if (is_comma) begin
            // The next edge carries bit 7 of a fresh byte.
            bit_cnt <= 3'd0;
            bc_cnt  <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state <= SYNC;
            end
          end
        end

        SYNC: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              // Saturates at LOCK_N because reaching it leaves SYNC.
              if (bc_cnt + 4'd1 >= LOCK_N) begin
                bc_cnt   <= LOCK_N;
                state    <= ACTIVE;
                active_q <= 1'b1;
              end else begin
                bc_cnt <= bc_cnt + 4'd1;
              end
            end else begin
              // A comma matched across a byte boundary lands here.
              bc_cnt <= 4'd0;
              state  <= SEARCH;
            end
          end
        end

        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              idle_q <= 1'b1;
            end else begin
              data_q  <= cand;
              valid_q <= 1'b1;
              idle_q  <= 1'b0;
            end
          end
        end

        default: state <= SEARCH;
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.active_out = active_q;
  assign bus.idle_out   = idle_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo -- directed self-checking bench for serial_paralelo.
// Each send_bit drives one serial bit, waits for the rising edge and
// samples outputs 1 time unit later; strobes are logged with the edge
// number (counted from the last reset release) at which they appeared.
module tb_serial_paralelo;

  logic clk_32f;
  logic reset;

  serial_paralelo_if bus ();

  serial_paralelo #(.LOCK_BC(4), .IDLE_CHAR(8'hBC)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  int n_cmp;
  int n_err;
  int edge_cnt;
  int act_edge;
  logic [7:0] q_data[$];
  int         q_edge[$];

  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
    edge_cnt++;
    if (bus.valid_out === 1'b1) begin
      q_data.push_back(bus.data_out);
      q_edge.push_back(edge_cnt);
    end
    if (bus.active_out === 1'b1 && act_edge == 0) act_edge = edge_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    bus.data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    reset    = 1'b0;
    edge_cnt = 0;
    act_edge = 0;
    q_data.delete();
    q_edge.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = i[0];
      @(posedge clk_32f);
      #1;
      n_cmp++;
      if ({bus.data_out, bus.valid_out, bus.active_out, bus.idle_out} !== 11'd0) begin
        n_err++;
        $display("FAIL reset_outputs edge %0d: got data=%h v=%b a=%b i=%b, want all 0",
                 i, bus.data_out, bus.valid_out, bus.active_out, bus.idle_out);
      end
    end
    reset    = 1'b0;
    edge_cnt = 0;
    act_edge = 0;
    q_data.delete();
    q_edge.delete();
    for (int i = 0; i < 48; i++) send_bit(1'b0);
    n_cmp++;
    if (act_edge != 0) begin
      n_err++;
      $display("FAIL reset_zero_stream_active: active rose at edge %0d, want never", act_edge);
    end
    n_cmp++;
    if (q_data.size() != 0) begin
      n_err++;
      $display("FAIL reset_zero_stream_strobes: got %0d strobes, want 0", q_data.size());
    end
  endtask

  task automatic test_lock();
    apply_reset();
    repeat (4) send_byte(8'hBC);
    send_byte(8'hA5);
    send_byte(8'h3C);
    n_cmp++;
    if (act_edge != 32) begin
      n_err++;
      $display("FAIL lock_active_edge: got %0d, want 32", act_edge);
    end
    n_cmp++;
    if (q_data.size() != 2) begin
      n_err++;
      $display("FAIL lock_strobe_count: got %0d, want 2", q_data.size());
    end else begin
      n_cmp++;
      if (q_data[0] !== 8'hA5 || q_edge[0] != 40) begin
        n_err++;
        $display("FAIL lock_first_byte: got %h@%0d, want a5@40", q_data[0], q_edge[0]);
      end
      n_cmp++;
      if (q_data[1] !== 8'h3C || q_edge[1] != 48) begin
        n_err++;
        $display("FAIL lock_second_byte: got %h@%0d, want 3c@48", q_data[1], q_edge[1]);
      end
    end
  endtask

  task automatic test_misalign();
    apply_reset();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (5) send_byte(8'hBC);
    send_byte(8'h81);
    n_cmp++;
    if (act_edge != 35) begin
      n_err++;
      $display("FAIL misalign_active_edge: got %0d, want 35", act_edge);
    end
    n_cmp++;
    if (q_data.size() != 1 || q_data[0] !== 8'h81 || q_edge[0] != 51) begin
      n_err++;
      $display("FAIL misalign_strobe: got n=%0d first=%h@%0d, want n=1 81@51",
               q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'hxx,
               (q_edge.size() > 0) ? q_edge[0] : -1);
    end
  endtask

  task automatic test_broken_sync();
    apply_reset();
    repeat (2) send_byte(8'hBC);
    send_byte(8'h55);
    n_cmp++;
    if (bus.active_out !== 1'b0 || q_data.size() != 0) begin
      n_err++;
      $display("FAIL broken_after_55: got active=%b strobes=%0d, want 0/0",
               bus.active_out, q_data.size());
    end
    repeat (4) send_byte(8'hBC);
    send_byte(8'h12);
    n_cmp++;
    if (act_edge != 56) begin
      n_err++;
      $display("FAIL broken_active_edge: got %0d, want 56", act_edge);
    end
    n_cmp++;
    if (q_data.size() != 1 || q_data[0] !== 8'h12 || q_edge[0] != 64) begin
      n_err++;
      $display("FAIL broken_strobe: got n=%0d first=%h@%0d, want n=1 12@64",
               q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'hxx,
               (q_edge.size() > 0) ? q_edge[0] : -1);
    end
  endtask

  task automatic test_idle_active();
    logic [7:0] seq [4];
    logic [7:0] exp_data [4];
    logic       exp_idle [4];
    seq      = '{8'h7E, 8'hBC, 8'hBC, 8'h01};
    exp_data = '{8'h7E, 8'h7E, 8'h7E, 8'h01};
    exp_idle = '{1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    repeat (4) send_byte(8'hBC);
    for (int k = 0; k < 4; k++) begin
      send_byte(seq[k]);
      n_cmp++;
      if (bus.data_out !== exp_data[k] || bus.idle_out !== exp_idle[k]) begin
        n_err++;
        $display("FAIL idle_byte%0d: got data=%h idle=%b, want data=%h idle=%b",
                 k, bus.data_out, bus.idle_out, exp_data[k], exp_idle[k]);
      end
    end
    n_cmp++;
    if (q_data.size() != 2) begin
      n_err++;
      $display("FAIL idle_strobe_count: got %0d, want 2", q_data.size());
    end else begin
      n_cmp++;
      if (q_data[0] !== 8'h7E || q_edge[0] != 40 || q_data[1] !== 8'h01 || q_edge[1] != 64) begin
        n_err++;
        $display("FAIL idle_strobes: got %h@%0d %h@%0d, want 7e@40 01@64",
                 q_data[0], q_edge[0], q_data[1], q_edge[1]);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] partial;
    partial = 8'hC3;
    apply_reset();
    repeat (4) send_byte(8'hBC);
    send_byte(8'hA5);
    n_cmp++;
    if (bus.data_out !== 8'hA5 || bus.active_out !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_pre: got data=%h active=%b, want a5/1",
               bus.data_out, bus.active_out);
    end
    for (int i = 7; i >= 4; i--) send_bit(partial[i]);
    reset = 1'b1;
    send_bit(partial[3]);
    n_cmp++;
    if ({bus.data_out, bus.valid_out, bus.active_out, bus.idle_out} !== 11'd0) begin
      n_err++;
      $display("FAIL midreset_clear: got data=%h v=%b a=%b i=%b, want all 0",
               bus.data_out, bus.valid_out, bus.active_out, bus.idle_out);
    end
    reset    = 1'b0;
    edge_cnt = 0;
    act_edge = 0;
    q_data.delete();
    q_edge.delete();
    repeat (3) send_byte(8'hBC);
    send_byte(8'h99);
    n_cmp++;
    if (act_edge != 0 || q_data.size() != 0) begin
      n_err++;
      $display("FAIL midreset_three_commas: got active_edge=%0d strobes=%0d, want 0/0",
               act_edge, q_data.size());
    end
    repeat (4) send_byte(8'hBC);
    send_byte(8'h42);
    n_cmp++;
    if (act_edge != 64 || q_data.size() != 1 || q_data[0] !== 8'h42 || q_edge[0] != 72) begin
      n_err++;
      $display("FAIL midreset_relock: got active_edge=%0d n=%0d first=%h@%0d, want 64 1 42@72",
               act_edge, q_data.size(), (q_data.size() > 0) ? q_data[0] : 8'hxx,
               (q_edge.size() > 0) ? q_edge[0] : -1);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    edge_cnt    = 0;
    act_edge    = 0;
    reset       = 1'b1;
    bus.data_in = 1'b0;
    test_reset();
    test_lock();
    test_misalign();
    test_broken_sync();
    test_idle_active();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Receive-side deserializer: turns the MSB-first serial bit stream from the transmit side back into bytes.
- The link carries data bytes when valid and the idle/comma character 0xBC (bit order 1,0,1,1,1,1,0,0) when idle.
- Block finds byte alignment by hunting for 0xBC, locks after LOCK_BC consecutive aligned commas, then presents each non-comma byte with a one-cycle valid strobe.
- Sits at the receive end of the lane, runs at the bit rate (one bit per clk_32f cycle), and feeds the byte-domain logic.

Parameters:
- LOCK_BC, 4: consecutive byte-aligned 0xBC characters required to declare lock (legal range 1..15).
- IDLE_CHAR, 8'hBC: comma/idle character used for alignment and idle detection.

Ports:
- clk_32f  input  1  bit-rate clock; the only clock. Every edge samples one serial bit.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial data, MSB of each byte first.
- data_out  output  8  last received data byte; held between strobes.
- valid_out  output  1  one-cycle pulse when data_out is loaded with a new non-comma byte.
- active_out  output  1  high while locked (state ACTIVE).
- idle_out  output  1  high in ACTIVE when the most recent completed byte was IDLE_CHAR.

Behaviour:
- Interface: one clock, clk_32f; reset is synchronous and active-high. All outputs are registered.
- Reset (sampled high on an edge):
  - data_out=8'h00, valid_out=0, active_out=0, idle_out=0.
  - Shift register=0, bit_cnt=0, bc_cnt=0, state=SEARCH.
  - Reset overrides everything, including mid-byte and while ACTIVE. Alignment is lost and must be reacquired.
- Shift: every non-reset edge, sr <= {sr[6:0], data_in}. The candidate byte at that edge is cand = {sr[6:0], data_in}.
- States:
  - SEARCH (bit-level hunt): every edge compare cand to IDLE_CHAR.
    - On match: bit_cnt<=0 (the next bit is bit 7 of a new byte) and bc_cnt<=1.
    - If LOCK_BC==1, go directly to ACTIVE; otherwise go to SYNC.
    - Outputs stay at their reset values in SEARCH.
  - SYNC (byte-level confirm): bit_cnt increments every edge, wrapping 7->0. At a byte boundary (edge with bit_cnt==7), evaluate cand:
    - cand==IDLE_CHAR: bc_cnt++; if the new count equals LOCK_BC, go to ACTIVE.
    - cand!=IDLE_CHAR: bc_cnt<=0 and return to SEARCH. The bit hunt resumes on the following edge.
  - ACTIVE: active_out=1; bit_cnt keeps wrapping. At each boundary edge:
    - cand!=IDLE_CHAR: data_out<=cand, valid_out<=1, idle_out<=0.
    - cand==IDLE_CHAR: data_out unchanged, valid_out<=0, idle_out<=1.
    - On all non-boundary edges valid_out<=0.
    - Once entered, ACTIVE is left only by reset.
- Latency:
  - Byte bit 7 is sampled at edge k and bit 0 at edge k+7.
  - data_out and valid_out are updated at edge k+7 and are visible in the cycle after it.
  - Strobes are exactly 8 cycles apart for back-to-back data.
- Lock timing: the first strobe occurs on the first non-comma byte boundary after entering ACTIVE. No strobe is issued for the locking comma bytes.
- Boundary conditions:
  - A data byte equal to 0xBC is indistinguishable from idle and is never strobed. This is a link rule the transmit side honours.
  - A false 0xBC match across a byte boundary in SEARCH is rejected by SYNC on the next non-comma boundary.
  - bc_cnt saturates at LOCK_BC.

Test Plan:
- Reset: hold reset for 3 edges with data_in toggling -> all outputs 0 and state SEARCH. Release, then drive 0x00 bits continuously -> active_out stays 0 and no valid_out.
- Lock: send 4× 0xBC then 0xA5, 0x3C -> active_out rises at the boundary of the 4th 0xBC. valid_out pulses exactly twice, 8 cycles apart, with data_out=0xA5 then 0x3C.
- Misalignment: prefix 3 random bits before 5× 0xBC + 0x81 -> lock achieved, data_out=0x81 with one valid_out pulse.
- Broken sync: send 2× 0xBC, 0x55, then 4× 0xBC, 0x12 -> return to SEARCH after 0x55 with active_out=0 and no strobe. Lock after the later commas, then data_out=0x12 with valid_out.
- Idle in ACTIVE: locked, send 0x7E, 0xBC, 0xBC, 0x01 -> strobes for 0x7E and 0x01 only. idle_out=1 during the two commas, and data_out holds 0x7E until 0x01 arrives.
- Reset mid-byte in ACTIVE: assert reset after 4 bits of a byte -> outputs clear on that edge. After release, the block needs 4 fresh commas before any strobe.
